// File: rtl/wshb_if.sv
// Wishbone B4 bus bundle shared by the arbiter, its two requesters and the slave.
// The requester drives the master modport, and the responder drives the slave modport.
interface wshb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic [ADDR_W-1:0]     adr;
    logic [DATA_W/8-1:0]   sel;
    logic [DATA_W-1:0]     dat_ms;
    logic [DATA_W-1:0]     dat_sm;
    logic [2:0]            cti;
    logic [1:0]            bte;
    logic                  ack;
    logic                  err;
    logic                  rty;

    modport master (
        output cyc, stb, we, adr, sel, dat_ms, cti, bte,
        input  dat_sm, ack, err, rty
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_ms, cti, bte,
        output dat_sm, ack, err, rty
    );
endinterface

// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter that holds a grant for a whole cyc period, so bursts are never split.
// Define WB_ARB_ROUND_ROBIN_EN to select round-robin tie-breaks; otherwise DEFAULT_GRANT has fixed priority.
module wb_arbiter #(
    parameter int DEFAULT_GRANT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    wshb_if.slave       m0,
    wshb_if.slave       m1,
    wshb_if.master      s,
    output logic [1:0]  grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic DEF_IS_M1 = (DEFAULT_GRANT != 0);

    state_t state;
    state_t state_nxt;
    logic   last;
    logic   last_nxt;
    logic   tie_to_m1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            last  <= ~DEF_IS_M1;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    // Tie-break for two requests that arrive in the same cycle while the bus is idle
    always_comb begin
`ifdef WB_ARB_ROUND_ROBIN_EN
        tie_to_m1 = ~last;
`else
        tie_to_m1 = DEF_IS_M1;
`endif
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        unique case (state)
            IDLE: begin
                if (m0.cyc && m1.cyc) begin
                    state_nxt = tie_to_m1 ? GNT1 : GNT0;
                end else if (m0.cyc) begin
                    state_nxt = GNT0;
                end else if (m1.cyc) begin
                    state_nxt = GNT1;
                end
            end
            // When the owner releases the bus, a waiting master takes it on the same edge
            GNT0: begin
                if (!m0.cyc) begin
                    state_nxt = m1.cyc ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!m1.cyc) begin
                    state_nxt = m0.cyc ? GNT0 : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (state_nxt == GNT0 && state != GNT0) begin
            last_nxt = 1'b0;
        end else if (state_nxt == GNT1 && state != GNT1) begin
            last_nxt = 1'b1;
        end
    end

    always_comb begin
        grant    = 2'b00;
        s.cyc    = 1'b0;
        s.stb    = 1'b0;
        s.we     = 1'b0;
        s.adr    = '0;
        s.sel    = '0;
        s.dat_ms = '0;
        s.cti    = 3'b000;
        s.bte    = 2'b00;
        m0.ack   = 1'b0;
        m0.err   = 1'b0;
        m0.rty   = 1'b0;
        m1.ack   = 1'b0;
        m1.err   = 1'b0;
        m1.rty   = 1'b0;
        // Read data is qualified by ack, so both masters can see it
        m0.dat_sm = s.dat_sm;
        m1.dat_sm = s.dat_sm;
        unique case (state)
            GNT0: begin
                grant    = 2'b01;
                s.cyc    = m0.cyc;
                s.stb    = m0.stb;
                s.we     = m0.we;
                s.adr    = m0.adr;
                s.sel    = m0.sel;
                s.dat_ms = m0.dat_ms;
                s.cti    = m0.cti;
                s.bte    = m0.bte;
                m0.ack   = s.ack;
                m0.err   = s.err;
                m0.rty   = s.rty;
            end
            GNT1: begin
                grant    = 2'b10;
                s.cyc    = m1.cyc;
                s.stb    = m1.stb;
                s.we     = m1.we;
                s.adr    = m1.adr;
                s.sel    = m1.sel;
                s.dat_ms = m1.dat_ms;
                s.cti    = m1.cti;
                s.bte    = m1.bte;
                m1.ack   = s.ack;
                m1.err   = s.err;
                m1.rty   = s.rty;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: two scripted requesters and a wb_bram-like slave model.
// Read data is checked against a scoreboard queue for each master, and grant and timing are checked inline.
module tb_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  grant;
    int          vectors = 0;
    int          errors  = 0;

    wshb_if m0_bus ();
    wshb_if m1_bus ();
    wshb_if s_bus ();

    wb_arbiter #(.DEFAULT_GRANT(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .m0    (m0_bus),
        .m1    (m1_bus),
        .s     (s_bus),
        .grant (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave model: writes are acked in the same cycle, reads one cycle later, and burst acks stream.
    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];
    logic        rd_ack;
    logic [31:0] rd_dat;
    logic [7:0]  rd_adr;
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];

    assign rd_adr = (rd_ack && s_bus.cti == 3'b010) ? s_bus.adr[7:0] + 8'd1 : s_bus.adr[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_ack <= 1'b0;
        else        rd_ack <= s_bus.cyc & s_bus.stb & ~s_bus.we & (~rd_ack | (s_bus.cti == 3'b010));
    end

    always @(posedge clk) begin
        rd_dat <= mem[rd_adr];
        if (s_bus.cyc && s_bus.stb && s_bus.we)
            for (int b = 0; b < 4; b++)
                if (s_bus.sel[b]) mem[s_bus.adr[7:0]][8*b +: 8] <= s_bus.dat_ms[8*b +: 8];
    end

    assign s_bus.ack    = s_bus.cyc & s_bus.stb & (s_bus.bte == 2'b00) & (s_bus.we | rd_ack);
    assign s_bus.err    = 1'b0;
    assign s_bus.rty    = 1'b0;
    assign s_bus.dat_sm = rd_dat;

    // Scoreboard: every read ack pops the oldest expected word for that master
    always @(negedge clk) begin
        if (rst_n) begin
            if (m0_bus.cyc && m0_bus.stb && !m0_bus.we && m0_bus.ack) begin
                vectors++;
                if (exp_q0.size() == 0) begin
                    errors++; $display("FAIL m0_rdata: unexpected ack with data %h, no read outstanding", m0_bus.dat_sm);
                end else begin
                    logic [31:0] e0;
                    e0 = exp_q0.pop_front();
                    if (m0_bus.dat_sm !== e0) begin
                        errors++; $display("FAIL m0_rdata: got %h expected %h", m0_bus.dat_sm, e0);
                    end
                end
            end
            if (m1_bus.cyc && m1_bus.stb && !m1_bus.we && m1_bus.ack) begin
                vectors++;
                if (exp_q1.size() == 0) begin
                    errors++; $display("FAIL m1_rdata: unexpected ack with data %h, no read outstanding", m1_bus.dat_sm);
                end else begin
                    logic [31:0] e1;
                    e1 = exp_q1.pop_front();
                    if (m1_bus.dat_sm !== e1) begin
                        errors++; $display("FAIL m1_rdata: got %h expected %h", m1_bus.dat_sm, e1);
                    end
                end
            end
        end
    end

    task automatic set_req(input int m, input logic cyc, input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [2:0] cti);
        if (m == 0) begin
            m0_bus.cyc = cyc; m0_bus.stb = cyc; m0_bus.we = we; m0_bus.adr = adr;
            m0_bus.dat_ms = dat; m0_bus.sel = 4'hF; m0_bus.cti = cti; m0_bus.bte = 2'b00;
        end else begin
            m1_bus.cyc = cyc; m1_bus.stb = cyc; m1_bus.we = we; m1_bus.adr = adr;
            m1_bus.dat_ms = dat; m1_bus.sel = 4'hF; m1_bus.cti = cti; m1_bus.bte = 2'b00;
        end
    endtask

    task automatic push_exp(input int m, input logic [31:0] d);
        if (m == 0) exp_q0.push_back(d);
        else        exp_q1.push_back(d);
    endtask

    task automatic wait_done(input int m);
        int  n;
        bit  done;
        logic a;
        n = 0; done = 0;
        while (!done) begin
            @(negedge clk);
            a = (m == 0) ? m0_bus.ack : m1_bus.ack;
            if (a) done = 1;
            else begin
                n++;
                if (n > 40) begin
                    vectors++; errors++;
                    $display("FAIL ack_timeout_m%0d: ack=0 after %0d cycles, expected ack=1", m, n);
                    done = 1;
                end
            end
        end
        @(posedge clk); #1;
        set_req(m, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    endtask

    task automatic xfer(input int m, input logic we, input logic [7:0] adr, input logic [31:0] dat);
        set_req(m, 1'b1, we, {24'h0, adr}, dat, 3'b000);
        if (!we) push_exp(m, ref_mem[adr]);
        wait_done(m);
        if (we) ref_mem[adr] = dat;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        set_req(0, 1'b1, 1'b1, 32'h55, 32'h1234_5678, 3'b010);
        set_req(1, 1'b1, 1'b0, 32'h66, 32'h0, 3'b000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b expected 00", grant); end
        vectors++; if ({s_bus.cyc, s_bus.stb, s_bus.we} !== 3'b000) begin errors++; $display("FAIL reset_s_ctl: cyc/stb/we=%b expected 000", {s_bus.cyc, s_bus.stb, s_bus.we}); end
        vectors++; if (s_bus.adr !== 32'h0) begin errors++; $display("FAIL reset_s_adr: got %h expected 0", s_bus.adr); end
        vectors++; if ({s_bus.sel, s_bus.cti, s_bus.bte} !== 9'h0) begin errors++; $display("FAIL reset_s_sel_cti_bte: got %h expected 0", {s_bus.sel, s_bus.cti, s_bus.bte}); end
        vectors++; if (s_bus.dat_ms !== 32'h0) begin errors++; $display("FAIL reset_s_dat: got %h expected 0", s_bus.dat_ms); end
        vectors++; if ({m0_bus.ack, m0_bus.err, m0_bus.rty, m1_bus.ack, m1_bus.err, m1_bus.rty} !== 6'b0) begin errors++; $display("FAIL reset_m_resp: got %b expected 000000", {m0_bus.ack, m0_bus.err, m0_bus.rty, m1_bus.ack, m1_bus.err, m1_bus.rty}); end
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_idle_after_release: grant=%b expected 00", grant); end
    endtask

    task automatic test_single;
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 3'b000);
        @(negedge clk);
        vectors++; if (s_bus.cyc !== 1'b0) begin errors++; $display("FAIL single_wr_latency: s.cyc=%b expected 0", s_bus.cyc); end
        @(posedge clk); #1; @(negedge clk);
        vectors++; if (s_bus.cyc !== 1'b1 || grant !== 2'b01) begin errors++; $display("FAIL single_wr_grant: s.cyc=%b grant=%b expected 1/01", s_bus.cyc, grant); end
        vectors++; if (m0_bus.ack !== 1'b1 || m1_bus.ack !== 1'b0) begin errors++; $display("FAIL single_wr_ack: m0.ack=%b m1.ack=%b expected 1/0", m0_bus.ack, m1_bus.ack); end
        vectors++; if (s_bus.adr !== 32'h10 || s_bus.dat_ms !== 32'hDEAD_BEEF || s_bus.sel !== 4'hF) begin errors++; $display("FAIL single_wr_mux: adr=%h dat=%h sel=%h expected 10/deadbeef/f", s_bus.adr, s_bus.dat_ms, s_bus.sel); end
        @(posedge clk); #1;
        ref_mem[8'h10] = 32'hDEAD_BEEF;
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        @(negedge clk);
        vectors++; if (grant !== 2'b01 || s_bus.cyc !== 1'b0) begin errors++; $display("FAIL single_release: grant=%b s.cyc=%b expected 01/0", grant, s_bus.cyc); end
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b000);
        push_exp(0, ref_mem[8'h10]);
        @(negedge clk);
        vectors++; if (s_bus.cyc !== 1'b0) begin errors++; $display("FAIL single_rd_latency: s.cyc=%b expected 0", s_bus.cyc); end
        @(posedge clk); #1; @(negedge clk);
        vectors++; if (s_bus.cyc !== 1'b1 || m0_bus.ack !== 1'b0) begin errors++; $display("FAIL single_rd_first: s.cyc=%b m0.ack=%b expected 1/0", s_bus.cyc, m0_bus.ack); end
        @(posedge clk); #1; @(negedge clk);
        vectors++; if (m0_bus.ack !== 1'b1 || m1_bus.ack !== 1'b0 || grant !== 2'b01) begin errors++; $display("FAIL single_rd_ack: m0.ack=%b m1.ack=%b grant=%b expected 1/0/01", m0_bus.ack, m1_bus.ack, grant); end
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        idle_cycles(2);
    endtask

    task automatic run_pair(input logic [1:0] exp_g[8], input logic exp_c[8], input string tag);
        logic [1:0] g[8];
        logic       c[8];
        fork
            xfer(0, 1'b0, 8'h10, 32'h0);
            xfer(1, 1'b0, 8'h11, 32'h0);
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                g[i] = grant;
                c[i] = s_bus.cyc;
            end
        join
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (g[i] !== exp_g[i] || c[i] !== exp_c[i]) begin
                errors++; $display("FAIL %s cycle %0d: grant=%b s.cyc=%b expected %b/%b", tag, i, g[i], c[i], exp_g[i], exp_c[i]);
            end
        end
        idle_cycles(2);
    endtask

    task automatic test_simultaneous;
        logic [1:0] g1[8];
        logic [1:0] g2[8];
        logic       cexp[8];
        g1   = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b00};
        cexp = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
`ifdef WB_ARB_ROUND_ROBIN_EN
        g2   = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b00};
`else
        g2   = g1;
`endif
        run_pair(g1, cexp, "simul_round1");
        // m0 alone takes the bus, so that last points at m0 before the second tie
        xfer(0, 1'b0, 8'h12, 32'h0);
        idle_cycles(2);
        run_pair(g2, cexp, "simul_round2");
    endtask

    task automatic test_burst;
        int ack_cyc[4];
        int m0_ack_at;
        m0_ack_at = 0;
        ack_cyc = '{0, 0, 0, 0};
        fork
            begin
                int beat;
                int n;
                logic ackd;
                beat = 0; n = 0;
                set_req(1, 1'b1, 1'b0, 32'h20, 32'h0, 3'b010);
                for (int i = 0; i < 4; i++) push_exp(1, ref_mem[8'h20 + i]);
                while (beat < 4 && n < 40) begin
                    @(negedge clk); n++;
                    ackd = m1_bus.ack;
                    if (ackd) begin ack_cyc[beat] = n; beat++; end
                    @(posedge clk); #1;
                    if (beat == 4) set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
                    else if (ackd) set_req(1, 1'b1, 1'b0, 32'h20 + beat, 32'h0, (beat == 3) ? 3'b111 : 3'b010);
                end
                vectors++; if (beat != 4) begin errors++; $display("FAIL burst_beats: got %0d acks expected 4", beat); end
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                xfer(0, 1'b0, 8'h10, 32'h0);
            end
            for (int i = 1; i <= 14; i++) begin
                @(negedge clk);
                if (grant == 2'b10) begin
                    vectors++;
                    if (m0_bus.ack !== 1'b0) begin errors++; $display("FAIL burst_m0_blocked cycle %0d: m0.ack=%b expected 0", i, m0_bus.ack); end
                end
                if (m0_bus.ack && m0_ack_at == 0) begin
                    m0_ack_at = i;
                    vectors++;
                    if (grant !== 2'b01) begin errors++; $display("FAIL burst_m0_grant: grant=%b expected 01", grant); end
                end
            end
        join
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (ack_cyc[i] != 3 + i) begin errors++; $display("FAIL burst_ack_cycle beat %0d: got cycle %0d expected %0d", i, ack_cyc[i], 3 + i); end
        end
        vectors++; if (m0_ack_at != 9) begin errors++; $display("FAIL burst_m0_after: m0 ack at cycle %0d expected 9", m0_ack_at); end
        idle_cycles(2);
    endtask

    task automatic test_back_to_back;
        logic [1:0] g[11];
        logic       c[11];
        logic [1:0] eg[11];
        logic       ec[11];
        eg = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
        ec = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        fork
            begin
                set_req(0, 1'b1, 1'b1, 32'h30, 32'hC0DE_0000, 3'b000);
                @(posedge clk); #1;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    vectors++;
                    if (m0_bus.ack !== 1'b1 || m1_bus.ack !== 1'b0) begin errors++; $display("FAIL b2b_write %0d: m0.ack=%b m1.ack=%b expected 1/0", i, m0_bus.ack, m1_bus.ack); end
                    ref_mem[8'h30 + i] = 32'hC0DE_0000 + i;
                    @(posedge clk); #1;
                    if (i < 3) set_req(0, 1'b1, 1'b1, 32'h31 + i, 32'hC0DE_0001 + i, 3'b000);
                    else       set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
                end
                @(posedge clk); #1;
                xfer(0, 1'b0, 8'h33, 32'h0);
            end
            begin
                @(posedge clk); #1;
                xfer(1, 1'b0, 8'h11, 32'h0);
            end
            for (int i = 0; i < 11; i++) begin
                @(negedge clk);
                g[i] = grant;
                c[i] = s_bus.cyc;
            end
        join
        for (int i = 0; i < 11; i++) begin
            vectors++;
            if (g[i] !== eg[i] || c[i] !== ec[i]) begin
                errors++; $display("FAIL b2b cycle %0d: grant=%b s.cyc=%b expected %b/%b", i, g[i], c[i], eg[i], ec[i]);
            end
        end
        idle_cycles(2);
    endtask

    task automatic test_reset_mid_burst;
        int beats;
        int n;
        logic ackd;
        beats = 0; n = 0;
        set_req(0, 1'b1, 1'b0, 32'h20, 32'h0, 3'b010);
        for (int i = 0; i < 4; i++) push_exp(0, ref_mem[8'h20 + i]);
        while (beats < 2 && n < 20) begin
            @(negedge clk); n++;
            ackd = m0_bus.ack;
            if (ackd) beats++;
            @(posedge clk); #1;
            if (ackd) set_req(0, 1'b1, 1'b0, 32'h20 + beats, 32'h0, 3'b010);
        end
        #1;
        vectors++; if (m0_bus.ack !== 1'b1 || grant !== 2'b01) begin errors++; $display("FAIL rst_burst_beat3: m0.ack=%b grant=%b expected 1/01", m0_bus.ack, grant); end
        rst_n = 1'b0;
        #1;
        vectors++; if (s_bus.cyc !== 1'b0 || m0_bus.ack !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL rst_async: s.cyc=%b m0.ack=%b grant=%b expected 0/0/00", s_bus.cyc, m0_bus.ack, grant); end
        vectors++; if (s_bus.adr !== 32'h0 || s_bus.cti !== 3'b000) begin errors++; $display("FAIL rst_async_mux: adr=%h cti=%b expected 0/000", s_bus.adr, s_bus.cti); end
        exp_q0.delete();
        set_req(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b000);
        set_req(1, 1'b1, 1'b0, 32'h11, 32'h0, 3'b000);
        @(posedge clk); #1;
        vectors++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_hold: grant=%b expected 00", grant); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        push_exp(0, ref_mem[8'h10]);
        push_exp(1, ref_mem[8'h11]);
        @(negedge clk);
        vectors++; if (grant !== 2'b00 || s_bus.cyc !== 1'b0) begin errors++; $display("FAIL rst_release: grant=%b s.cyc=%b expected 00/0", grant, s_bus.cyc); end
        @(posedge clk); #1; @(negedge clk);
        vectors++; if (grant !== 2'b01 || s_bus.cyc !== 1'b1 || m1_bus.ack !== 1'b0) begin errors++; $display("FAIL rst_first_arb: grant=%b s.cyc=%b m1.ack=%b expected 01/1/0", grant, s_bus.cyc, m1_bus.ack); end
        @(posedge clk); #1;
        fork
            wait_done(0);
            wait_done(1);
        join
        idle_cycles(2);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'hA500_0000 + i;
            ref_mem[i] = 32'hA500_0000 + i;
        end
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        test_reset;
        test_single;
        test_simultaneous;
        test_burst;
        test_back_to_back;
        test_reset_mid_burst;
        vectors++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: %0d/%0d reads outstanding, expected 0/0", exp_q0.size(), exp_q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
